// File: rtl/data_sram_resp.sv
// data_sram_resp: word-organised data SRAM responder with byte lanes, error flagging, counters and write trace
module data_sram_resp #(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic        trace_wr_valid,
    output logic [31:0] trace_wr_addr,
    output logic [31:0] trace_wr_data
);
    logic [31:0] mem [1 << DEPTH_LOG2];
    logic [29:0] off_w;
    logic [DEPTH_LOG2-1:0] idx;
    logic in_range, misaligned, accept, reject, is_wr, is_rd;
    logic [31:0] old_word, merged;
    logic [31:0] rdata_q, rdata_d, err_addr_q, err_addr_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [31:0] tr_addr_q, tr_addr_d, tr_data_q, tr_data_d;
    logic err_valid_q, err_valid_d, tr_valid_q, tr_valid_d;

    // Word offset from the base; an address below the base wraps large and lands out of range
    assign off_w      = data_sram_addr[31:2] - BASE_ADDR[31:2];
    assign in_range   = off_w[29:DEPTH_LOG2] == '0;
    assign idx        = off_w[DEPTH_LOG2-1:0];
    assign misaligned = (data_sram_addr[1:0] != 2'b00) && (data_sram_we == 4'hF);
    assign accept     = data_sram_en && in_range && !misaligned;
    assign reject     = data_sram_en && !accept;
    assign is_wr      = accept && (data_sram_we != 4'h0);
    assign is_rd      = accept && (data_sram_we == 4'h0);
    assign old_word   = mem[idx];

    // Byte-lane merge of the write data into the current word
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++)
            if (data_sram_we[i]) merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end

    // Next-state for the response, error, counter and trace registers; read-first returns the old word
    always_comb begin
        rdata_d     = accept ? old_word : (reject ? 32'h0 : rdata_q);
        err_valid_d = reject;
        err_addr_d  = reject ? data_sram_addr : err_addr_q;
        rd_cnt_d    = rd_cnt_q + {31'b0, is_rd};
        wr_cnt_d    = wr_cnt_q + {31'b0, is_wr};
        tr_valid_d  = is_wr;
        tr_addr_d   = is_wr ? {data_sram_addr[31:2], 2'b00} : tr_addr_q;
        tr_data_d   = is_wr ? merged : tr_data_q;
    end

    // Storage array: not reset, and an access in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (!reset && is_wr) mem[idx] <= merged;
    end

    // Registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q     <= 32'h0;
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
            rd_cnt_q    <= 32'h0;
            wr_cnt_q    <= 32'h0;
            tr_valid_q  <= 1'b0;
            tr_addr_q   <= 32'h0;
            tr_data_q   <= 32'h0;
        end else begin
            rdata_q     <= rdata_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            tr_valid_q  <= tr_valid_d;
            tr_addr_q   <= tr_addr_d;
            tr_data_q   <= tr_data_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign err_valid       = err_valid_q;
    assign err_addr        = err_addr_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;
    assign trace_wr_valid  = tr_valid_q;
    assign trace_wr_addr   = tr_addr_q;
    assign trace_wr_data   = tr_data_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed self-checking bench for data_sram_resp
module tb_data_sram_resp;
    localparam logic [31:0] B = 32'h1c00_0000;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0;
    logic [3:0] we = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata, err_addr, rd_cnt, wr_cnt, tr_addr, tr_data;
    logic err_valid, tr_valid;
    int total = 0, bad = 0;

    data_sram_resp dut (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .err_valid(err_valid), .err_addr(err_addr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .trace_wr_valid(tr_valid), .trace_wr_addr(tr_addr), .trace_wr_data(tr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock cycle with the given request; returns 1 time unit after the edge
    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_errv", {31'b0, err_valid}, 0);
        chk("rst_erra", err_addr, 0);
        chk("rst_rdcnt", rd_cnt, 0);
        chk("rst_wrcnt", wr_cnt, 0);
        chk("rst_trv", {31'b0, tr_valid}, 0);
        chk("rst_tra", tr_addr, 0);
        chk("rst_trd", tr_data, 0);
        reset = 1'b0;

        cyc(1, 4'hF, B + 8, 32'hDEAD_BEEF);
        chk("wr_trv", {31'b0, tr_valid}, 1);
        chk("wr_tra", tr_addr, B + 8);
        chk("wr_trd", tr_data, 32'hDEAD_BEEF);
        chk("wr_cnt1", wr_cnt, 1);
        cyc(1, 4'h0, B + 8, 0);
        chk("rd_data", rdata, 32'hDEAD_BEEF);
        chk("rd_cnt1", rd_cnt, 1);
        chk("rd_wrcnt", wr_cnt, 1);
        chk("rd_trv0", {31'b0, tr_valid}, 0);

        cyc(1, 4'hF, B + 12, 32'h1122_3344);
        cyc(1, 4'b0101, B + 12, 32'hAABB_CCDD);
        chk("merge_trd", tr_data, 32'h11BB_33DD);
        chk("merge_old", rdata, 32'h1122_3344);
        cyc(1, 4'h0, B + 12, 0);
        chk("merge_rd", rdata, 32'h11BB_33DD);

        cyc(1, 4'hF, B + 16, 32'h1);
        cyc(1, 4'hF, B + 16, 32'h2);
        chk("rf_old", rdata, 32'h1);
        cyc(1, 4'h0, B + 16, 0);
        chk("rf_new", rdata, 32'h2);
        chk("cnt_wr5", wr_cnt, 5);
        chk("cnt_rd3", rd_cnt, 3);

        cyc(0, 4'hF, B + 16, 32'h9);
        chk("idle_rdata", rdata, 32'h2);
        chk("idle_trv", {31'b0, tr_valid}, 0);
        chk("idle_wrcnt", wr_cnt, 5);

        cyc(1, 4'hF, B, 32'hCAFE_0000);
        cyc(1, 4'hF, B + (32'd4 << 16), 32'h5555_5555);
        chk("oor_errv", {31'b0, err_valid}, 1);
        chk("oor_erra", err_addr, B + (32'd4 << 16));
        chk("oor_rdata", rdata, 0);
        chk("oor_wrcnt", wr_cnt, 6);
        chk("oor_trv", {31'b0, tr_valid}, 0);
        cyc(1, 4'h0, B, 0);
        chk("oor_pulse", {31'b0, err_valid}, 0);
        chk("oor_hold", err_addr, B + (32'd4 << 16));
        chk("oor_arr", rdata, 32'hCAFE_0000);

        cyc(1, 4'hF, B + 2, 32'h7777_7777);
        chk("mis_errv", {31'b0, err_valid}, 1);
        chk("mis_erra", err_addr, B + 2);
        chk("mis_rdata", rdata, 0);
        chk("mis_wrcnt", wr_cnt, 6);
        cyc(1, 4'b0011, B + 2, 32'h0000_BEEF);
        chk("part_errv", {31'b0, err_valid}, 0);
        chk("part_tra", tr_addr, B);
        chk("part_trd", tr_data, 32'hCAFE_BEEF);
        cyc(1, 4'h0, B - 4, 0);
        chk("low_errv", {31'b0, err_valid}, 1);
        chk("low_erra", err_addr, B - 4);
        chk("low_rdcnt", rd_cnt, 4);

        for (int i = 0; i < 8; i++) cyc(1, 4'hF, B + 32'h100 + 4 * i, 32'hA000_0000 + i);
        reset = 1'b1;
        cyc(1, 4'hF, B + 32'h100, 32'h0000_0BAD);
        reset = 1'b0;
        chk("rst2_rdata", rdata, 0);
        chk("rst2_rdcnt", rd_cnt, 0);
        chk("rst2_wrcnt", wr_cnt, 0);
        chk("rst2_trv", {31'b0, tr_valid}, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 4'h0, B + 32'h100 + 4 * i, 0);
            chk($sformatf("b2b_%0d", i), rdata, 32'hA000_0000 + i);
        end
        chk("b2b_rdcnt", rd_cnt, 8);
        chk("b2b_wrcnt", wr_cnt, 0);

        for (int i = 0; i < 4; i++) cyc(1, 4'h0, B + 32'h100 + 4 * i, 0);
        reset = 1'b1;
        cyc(1, 4'h0, B + 32'h110, 0);
        reset = 1'b0;
        chk("mid_rdata", rdata, 0);
        chk("mid_rdcnt", rd_cnt, 0);
        cyc(1, 4'h0, B + 32'h110, 0);
        chk("mid_keep", rdata, 32'hA000_0004);
        chk("mid_rdcnt1", rd_cnt, 1);

        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_q;
        chk("wrap_pre", wr_cnt, 32'hFFFF_FFFF);
        cyc(1, 4'hF, B + 32'h200, 32'h1234_5678);
        chk("wrap_cnt", wr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
